// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier: one multiplier bit per cycle, LSB first.
// Define SHIFT_ADD_MULT_SIGNED_EN for a two's-complement build (subtracts on the final bit).
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [PW-1:0]    product_q, product_d;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    addend;
  logic             last_iter;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  assign a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
`else
  assign a_ext = {{WIDTH{1'b0}}, a_q};
`endif

  assign addend    = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        // The multiplier MSB carries negative weight in two's complement.
        acc_d = last_iter ? (acc_q - addend) : (acc_q + addend);
`else
        acc_d = acc_q + addend;
`endif
        if (last_iter) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == CALC);
    product_d   = out_valid_d ? acc_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      product_q   <= product_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed testbench for shift_add_mult: WIDTH=8 instance plus an exhaustive WIDTH=2 instance.
// Expected values follow SHIFT_ADD_MULT_SIGNED_EN when it is defined for the build.
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [7:0]  a, b;
  logic        in_ready, out_valid, busy;
  logic [15:0] product;

  logic        in_valid2, out_ready2;
  logic [1:0]  a2, b2;
  logic        in_ready2, out_valid2, busy2;
  logic [3:0]  product2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  shift_add_mult #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .product(product2), .busy(busy2)
  );

  // One complete WIDTH=8 transaction; inputs are scrambled after acceptance.
  task automatic op8(input string name, input logic [7:0] va, input logic [7:0] vb,
                     input logic [15:0] exp);
    int cycles;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    in_valid = 1'b1; a = va; b = vb;
    @(negedge clk);
    in_valid = 1'b0; a = ~va; b = ~vb;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s busy/in_ready in CALC: got %b/%b want 1/0", name, busy, in_ready);
    end
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    n_checks++;
    if (cycles !== 8) begin
      n_fail++; $display("FAIL %s latency: got %0d want 8", name, cycles);
    end
    n_checks++;
    if (product !== exp) begin
      n_fail++; $display("FAIL %s product: got %h want %h", name, product, exp);
    end
    $display("op %s a=%h b=%h product=%h expected=%h latency=%0d", name, va, vb, product, exp, cycles);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || product !== 16'h0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s after handshake: out_valid=%b product=%h in_ready=%b want 0/0000/1",
                         name, out_valid, product, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0) begin
      n_fail++; $display("FAIL reset state: in_ready=%b out_valid=%b busy=%b product=%h want 1/0/0/0000",
                         in_ready, out_valid, busy, product);
    end
    n_checks++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || product2 !== 4'h0) begin
      n_fail++; $display("FAIL reset state w2: in_ready=%b out_valid=%b product=%h want 1/0/0",
                         in_ready2, out_valid2, product2);
    end
    $display("reset in_ready=%b out_valid=%b busy=%b product=%h", in_ready, out_valid, busy, product);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    op8("ff_ff", 8'hFF, 8'hFF, 16'h0001);
    op8("01_80", 8'h01, 8'h80, 16'hFF80);
    op8("80_80", 8'h80, 8'h80, 16'h4000);
    op8("7f_81", 8'h7F, 8'h81, 16'hC0FF);
    op8("fd_05", 8'hFD, 8'h05, 16'hFFF1);
`else
    op8("ff_ff", 8'hFF, 8'hFF, 16'hFE01);
    op8("01_80", 8'h01, 8'h80, 16'h0080);
    op8("80_80", 8'h80, 8'h80, 16'h4000);
    op8("7f_81", 8'h7F, 8'h81, 16'h3FFF);
    op8("fd_05", 8'hFD, 8'h05, 16'h04F1);
`endif
    op8("00_a5", 8'h00, 8'hA5, 16'h0000);
  endtask

  task automatic test_back_to_back();
    op8("b2b_1", 8'h12, 8'h34, 16'h03A8);
    op8("b2b_2", 8'h0B, 8'h07, 16'h004D);
  endtask

  task automatic test_backpressure();
    int cycles;
    logic [15:0] held;
    @(negedge clk);
    in_valid = 1'b1; a = 8'h0F; b = 8'h0D;
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    held = product;
    n_checks++;
    if (held !== 16'h00C3) begin
      n_fail++; $display("FAIL bp product: got %h want 00c3", held);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); a = 8'h55 + 8'(i); b = 8'h33;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || product !== 16'h00C3 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp hold %0d: out_valid=%b product=%h in_ready=%b want 1/00c3/0",
                           i, out_valid, product, in_ready);
      end
    end
    $display("backpressure held product=%h", product);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp release: out_valid=%b in_ready=%b busy=%b want 0/1/0",
                         out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    @(negedge clk);
    in_valid = 1'b1; a = 8'hC3; b = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0) begin
      n_fail++; $display("FAIL midreset: in_ready=%b out_valid=%b busy=%b product=%h want 1/0/0/0000",
                         in_ready, out_valid, busy, product);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL midreset spurious out_valid: got %0d want 0", pulses);
    end
    $display("reset mid-op aborted, spurious pulses=%0d", pulses);
    op8("post_rst", 8'h12, 8'h34, 16'h03A8);
  endtask

  task automatic test_width2();
    int cycles;
    int sa, sb;
    logic [3:0] exp;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a2 = 2'(i >> 2); b2 = 2'(i);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
      sa = (i >> 2) >= 2 ? (i >> 2) - 4 : (i >> 2);
      sb = (i & 3) >= 2 ? (i & 3) - 4 : (i & 3);
`else
      sa = i >> 2;
      sb = i & 3;
`endif
      exp = 4'(sa * sb);
      in_valid2 = 1'b1;
      @(negedge clk);
      in_valid2 = 1'b0;
      cycles = 0;
      while (out_valid2 !== 1'b1 && cycles < 20) begin
        @(negedge clk);
        cycles++;
      end
      n_checks++;
      if (cycles !== 2 || product2 !== exp) begin
        n_fail++; $display("FAIL w2 %0d*%0d: product=%h latency=%0d want %h latency 2",
                           i >> 2, i & 3, product2, cycles, exp);
      end
      $display("w2 a=%0d b=%0d product=%h expected=%h latency=%0d", i >> 2, i & 3, product2, exp, cycles);
      out_ready2 = 1'b1;
      @(negedge clk);
      out_ready2 = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_width2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
